// File: rtl/gcd_lcm_pkg.sv
// Shared types and width helpers for the multi-operand GCD/LCM engine.
// Optional LCM datapath is enabled with GCD_LCM_MULTI_LCM_EN.
package gcd_lcm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GCD_G = 3'd2,
    GCD_L = 3'd3,
    DIV   = 3'd4,
    MUL   = 3'd5,
    CHECK = 3'd6,
    DONE  = 3'd7
  } state_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_RUN  = 1'b1
  } core_state_t;

  // Bits needed to hold any value in 0..n.
  function automatic int bits_for(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gcd_core.sv
// Stein binary GCD: one reduction step per cycle, start/done handshake.
// done is combinational so the caller can chain a new start in the same cycle.
module gcd_core
  import gcd_lcm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int KW = bits_for(W);

  core_state_t  r_state;
  core_state_t  w_next;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [KW-1:0] r_k;
  logic         w_fin;
  logic         w_load;

  // Finished once either operand is zero; the other one (times 2^k) is the GCD.
  assign w_fin  = (r_state == C_RUN) && ((r_a == '0) || (r_b == '0));
  assign w_load = start && ((r_state == C_IDLE) || w_fin);
  assign done   = w_fin;
  assign result = (r_a | r_b) << r_k;

  always_comb begin
    w_next = r_state;
    case (r_state)
      C_IDLE:  if (start) w_next = C_RUN;
      C_RUN:   if (w_fin && !start) w_next = C_IDLE;
      default: w_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_k <= '0;
    end else if (w_load) begin
      r_a <= a;
      r_b <= b;
      r_k <= '0;
    end else if ((r_state == C_RUN) && !w_fin) begin
      if (!r_a[0] && !r_b[0]) begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
        r_k <= r_k + KW'(1);
      end else if (!r_a[0]) begin
        r_a <= r_a >> 1;
      end else if (!r_b[0]) begin
        r_b <= r_b >> 1;
      end else if (r_a >= r_b) begin
        // Difference of two odd values is even, so halve it in the same step.
        r_a <= (r_a - r_b) >> 1;
      end else begin
        r_b <= (r_b - r_a) >> 1;
      end
    end
  end

endmodule

// File: rtl/gcd_lcm_multi.sv
// Multi-operand running GCD/LCM engine around one shared Stein GCD core.
// Define GCD_LCM_MULTI_LCM_EN to build the LCM path (GCD_L, DIV, MUL); otherwise lcm/ovf read 0.
module gcd_lcm_multi
  import gcd_lcm_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int NUM_OPS = 4,
  parameter int LCM_W   = 2*SIZE+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  data_in,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [SIZE-1:0]  gcd,
  output logic [LCM_W-1:0] lcm,
  output logic             ovf
);

  localparam int CNT_W = bits_for(NUM_OPS);
`ifdef GCD_LCM_MULTI_LCM_EN
  localparam int CORE_W = LCM_W;
  localparam int DIV_W  = bits_for(LCM_W);
`else
  localparam int CORE_W = SIZE;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic [SIZE-1:0]   r_g;
  logic              w_accept;
  logic              w_first;
  logic              w_close;
  logic              w_core_start;
  logic              w_core_done;
  logic [CORE_W-1:0] w_core_a;
  logic [CORE_W-1:0] w_core_b;
  logic [CORE_W-1:0] w_core_res;

  // Operand stream: a transfer happens on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, data_in/in_last must be stable while in_valid is high.
  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_cnt == '0);
  assign w_close  = r_last || (r_cnt == CNT_W'(NUM_OPS));

  assign in_ready = (r_state == LOAD);
  assign busy     = (r_state != IDLE) && (r_state != DONE);
  assign done     = (r_state == DONE);
  assign gcd      = r_g;

`ifdef GCD_LCM_MULTI_LCM_EN
  logic [SIZE-1:0]       r_x;
  logic [LCM_W-1:0]      r_l;
  logic [LCM_W-1:0]      r_d;
  logic [LCM_W-1:0]      r_quo;
  logic [LCM_W-1:0]      r_rem;
  logic [DIV_W-1:0]      r_div_cnt;
  logic                  r_ovf;
  logic                  w_lcm_skip;
  logic                  w_div_ge;
  logic [LCM_W:0]        w_rem_sh;
  logic [LCM_W+SIZE-1:0] w_prod;

  // A zero or saturated LCM can never change again, so its path is bypassed.
  assign w_lcm_skip = (r_l == '0) || r_ovf || (r_x == '0);
  assign w_rem_sh   = {r_rem, r_quo[LCM_W-1]};
  assign w_div_ge   = (w_rem_sh >= {1'b0, r_d});
  assign w_prod     = (LCM_W+SIZE)'(r_quo) * (LCM_W+SIZE)'(r_x);
  assign lcm        = r_l;
  assign ovf        = r_ovf;
`else
  assign lcm = '0;
  assign ovf = 1'b0;
`endif

  gcd_core #(
    .W(CORE_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_core_start),
    .a      (w_core_a),
    .b      (w_core_b),
    .done   (w_core_done),
    .result (w_core_res)
  );

  always_comb begin
    w_next       = r_state;
    w_core_start = 1'b0;
    w_core_a     = CORE_W'(r_g);
    w_core_b     = CORE_W'(data_in);
    case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: begin
        if (w_accept) begin
          if (w_first) begin
            w_next = CHECK;
          end else begin
            w_core_start = 1'b1;
            w_next       = GCD_G;
          end
        end
      end
      GCD_G: begin
        if (w_core_done) begin
`ifdef GCD_LCM_MULTI_LCM_EN
          if (w_lcm_skip) begin
            w_next = CHECK;
          end else begin
            w_core_start = 1'b1;
            w_core_a     = r_l;
            w_core_b     = CORE_W'(r_x);
            w_next       = GCD_L;
          end
`else
          w_next = CHECK;
`endif
        end
      end
`ifdef GCD_LCM_MULTI_LCM_EN
      GCD_L: if (w_core_done) w_next = DIV;
      DIV:   if (r_div_cnt == DIV_W'(LCM_W-1)) w_next = MUL;
      MUL:   w_next = CHECK;
`endif
      CHECK:   w_next = w_close ? DONE : LOAD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_g     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt  <= '0;
            r_last <= 1'b0;
            r_g    <= '0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_last <= in_last;
            if (w_first) r_g <= data_in;
          end
        end
        GCD_G: if (w_core_done) r_g <= w_core_res[SIZE-1:0];
        default: ;
      endcase
    end
  end

`ifdef GCD_LCM_MULTI_LCM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_l       <= '0;
      r_d       <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_div_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_l   <= '0;
            r_ovf <= 1'b0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_x <= data_in;
            if (w_first) r_l <= LCM_W'(data_in);
          end
        end
        GCD_G: if (w_core_done && (r_x == '0)) r_l <= '0;
        GCD_L: begin
          if (w_core_done) begin
            r_d       <= w_core_res;
            r_quo     <= r_l;
            r_rem     <= '0;
            r_div_cnt <= '0;
          end
        end
        DIV: begin
          // Restoring division, one quotient bit per cycle, dividend shifted out of r_quo.
          r_quo     <= {r_quo[LCM_W-2:0], w_div_ge};
          r_rem     <= w_div_ge ? LCM_W'(w_rem_sh - {1'b0, r_d}) : LCM_W'(w_rem_sh);
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
        MUL: begin
          if (w_prod[LCM_W+SIZE-1:LCM_W] != '0) begin
            r_ovf <= 1'b1;
            r_l   <= '1;
          end else begin
            r_l <= w_prod[LCM_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_gcd_lcm_multi.sv
// Directed bench for gcd_lcm_multi; expectations follow GCD_LCM_MULTI_LCM_EN when defined.
module tb_gcd_lcm_multi;
  import gcd_lcm_pkg::*;

`ifdef GCD_LCM_MULTI_LCM_EN
  localparam bit LCM_EN = 1'b1;
`else
  localparam bit LCM_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data_in;
  logic        in_last;
  logic        busy;
  logic        done;
  logic [7:0]  gcd;
  logic [16:0] lcm;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  gcd_lcm_multi #(
    .SIZE(8), .NUM_OPS(4), .LCM_W(17)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .in_last  (in_last),
    .busy     (busy),
    .done     (done),
    .gcd      (gcd),
    .lcm      (lcm),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] x, input logic last, input string tag);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = x;
    in_last  = last;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " accept"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_result(input string tag, input logic [31:0] eg, input logic [31:0] el,
                            input logic [31:0] eo);
    chk({tag, " gcd"}, 32'(gcd), eg);
    chk({tag, " lcm"}, 32'(lcm), LCM_EN ? el : 32'd0);
    chk({tag, " ovf"}, 32'(ovf), LCM_EN ? eo : 32'd0);
  endtask

  initial begin
    int n;
    int accepted;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    in_last  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk_result("rst", 32'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: 100, 20
    pulse_start();
    chk("T1 busy", 32'(busy), 32'd1);
    chk("T1 in_ready", 32'(in_ready), 32'd1);
    send_op(8'd100, 1'b0, "T1 op0");
    send_op(8'd20, 1'b1, "T1 op1");
    wait_done("T1");
    chk_result("T1", 32'd20, 32'd100, 32'd0);
    @(negedge clk);
    chk("T1 idle in_ready", 32'(in_ready), 32'd0);
    chk("T1 done pulse", 32'(done), 32'd0);

    // T2: 12, 18, 30 with a start pulsed mid-job
    pulse_start();
    send_op(8'd12, 1'b0, "T2 op0");
    send_op(8'd18, 1'b0, "T2 op1");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("T2 busy after stray start", 32'(busy), 32'd1);
    send_op(8'd30, 1'b1, "T2 op2");
    wait_done("T2");
    chk_result("T2", 32'd6, 32'd180, 32'd0);

    // T3: zero operands
    pulse_start();
    send_op(8'd0, 1'b0, "T3a op0");
    send_op(8'd7, 1'b1, "T3a op1");
    wait_done("T3a");
    chk_result("T3a", 32'd7, 32'd0, 32'd0);
    pulse_start();
    send_op(8'd0, 1'b0, "T3b op0");
    send_op(8'd0, 1'b1, "T3b op1");
    wait_done("T3b");
    chk_result("T3b", 32'd0, 32'd0, 32'd0);

    // Single-operand job: done exactly two cycles after the accept
    pulse_start();
    send_op(8'd9, 1'b1, "T3s op0");
    chk("T3s done+1", 32'(done), 32'd0);
    @(negedge clk);
    chk("T3s done+2", 32'(done), 32'd1);
    chk_result("T3s", 32'd9, 32'd9, 32'd0);

    // T4: LCM overflow saturates, GCD continues
    pulse_start();
    send_op(8'd255, 1'b0, "T4 op0");
    send_op(8'd254, 1'b0, "T4 op1");
    send_op(8'd253, 1'b1, "T4 op2");
    wait_done("T4");
    chk_result("T4", 32'd1, 32'h1FFFF, 32'd1);

    // T5: auto-close after NUM_OPS accepts, fifth operand held off
    pulse_start();
    send_op(8'd8, 1'b0, "T5 op0");
    send_op(8'd12, 1'b0, "T5 op1");
    send_op(8'd16, 1'b0, "T5 op2");
    send_op(8'd4, 1'b0, "T5 op3");
    in_valid = 1'b1;
    data_in  = 8'd20;
    accepted = 0;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      if (in_ready === 1'b1) accepted++;
      @(negedge clk);
      n++;
    end
    chk("T5 done", 32'(done), 32'd1);
    chk("T5 fifth accepted", 32'(accepted), 32'd0);
    chk_result("T5", 32'd4, 32'd48, 32'd0);
    repeat (3) @(negedge clk);
    chk("T5 stall in_ready", 32'(in_ready), 32'd0);
    chk("T5 gcd held", 32'(gcd), 32'd4);
    in_valid = 1'b0;

    // T6: asynchronous reset in the middle of a job
    pulse_start();
    send_op(8'd200, 1'b0, "T6 op0");
    send_op(8'd150, 1'b0, "T6 op1");
`ifdef GCD_LCM_MULTI_LCM_EN
    n = 0;
    while (dut.r_state != DIV && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("T6 reached DIV", 32'(dut.r_state == DIV), 32'd1);
`endif
    chk("T6 busy before reset", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("T6 rst in_ready", 32'(in_ready), 32'd0);
    chk("T6 rst busy", 32'(busy), 32'd0);
    chk("T6 rst done", 32'(done), 32'd0);
    chk_result("T6 rst", 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    send_op(8'd9, 1'b0, "T6 op2");
    send_op(8'd6, 1'b1, "T6 op3");
    wait_done("T6");
    chk_result("T6", 32'd3, 32'd18, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
